custom_line_buffer_v5_sint18: RTL
=================================

// Module: custom_line_buffer_v5_sint18
// PURPOSE
// - Vertical window generator for the DFDD Burt pyramid. It sits directly upstream of the
//   5-tap vertical Burt filter (sint18 -> sint22).
// - Takes a raster stream of signed 18-bit pixels and emits 5x1 column windows
//   centred on row c, with c running from 0 to IMG_H-1. Rows outside the image read as 0.
// - Uses 4 line memories. Adds a FLUSH phase so the last 2 rows of each frame are also emitted.
// PARAMETERS
// - IMG_W   640  pixels per row; col_i range is 0..IMG_W-1
// - IMG_H   480  rows per frame; row_i range is 0..IMG_H-1; must be >= 4
// - DATA_W  18   pixel width, two's complement
// PORTS
// - clk_i      in   1          single clock; all state on rising edge
// - rst_i      in   1          reset, asynchronous and active-low
// - data_i     in   DATA_W     input pixel (signed)
// - col_i      in   16         input column
// - row_i      in   16         input row
// - valid_i    in   1          input pixel valid
// - window_o   out  DATA_W[5][1]  [0]=row c-2 .. [4]=row c+2
// - col_o      out  16         column of the window
// - row_o      out  16         centre row c
// - valid_o    out  1          window valid
// - busy_o     out  1          high during FLUSH; upstream must hold valid_i low
// - overflow_o out  1          sticky: valid_i was seen while busy_o was high
// BEHAVIOUR
// - Reset (rst_i=0, asynchronous): valid pipeline, valid_o, busy_o and overflow_o go to 0.
//   window_o, col_o and row_o go to 0. FSM goes to RUN. Line RAM contents are don't-care.
// - Line storage: slot s = row[1:0] holds the most recent row with that residue.
//   - RAMs are read-first: a read and a write at the same column in the same cycle return the old data.
//   - Each accepted pixel (r, x) reads all 4 slots at column x and writes data_i into slot r[1:0].
// - RUN, accepted pixel (r, x):
//   - r < 2: write only; no output.
//   - r >= 2: emit a window with c = r-2, col = x.
//   - Taps: [0] = row r-4, [1] = r-3, [2] = r-2, [3] = r-1, [4] = data_i.
//   - Any tap whose row index is < 0 is forced to 0. This is decided by row index, not by RAM contents.
// - Latency: valid_o is asserted exactly 2 cycles after the accepting valid_i edge.
//   - Stage 1 is the RAM read plus delay of data/col/row.
//   - Stage 2 is the output register.
//   - Throughput is 1 window per cycle. There is no backpressure downstream.
// - RUN -> FLUSH when pixel (IMG_H-1, IMG_W-1) is accepted. busy_o rises the next cycle.
// - FLUSH: an internal column counter fc (0..IMG_W-1) and pass p (0..1) produce one window per cycle.
//   - p=0 (c = IMG_H-2): taps are rows H-4, H-3, H-2, H-1, and [4]=0.
//   - p=1 (c = IMG_H-1): taps are rows H-3, H-2, H-1, and [3]=[4]=0.
//   - RAMs are not written during FLUSH. Same 2-cycle pipeline.
//   - After p=1, fc=IMG_W-1: return to RUN. busy_o falls the next cycle.
// - valid_i during FLUSH: the pixel is dropped (no RAM write, no output) and overflow_o is set.
//   overflow_o is cleared only by reset.
// - Out-of-order input (row_i jumps) is not checked. Behaviour follows the row-index rules above.
// - A new frame (row_i=0) may start the cycle after busy_o falls. Back-to-back frames need no idle gap.
// - Async reset mid-FLUSH or mid-frame: outputs are immediately invalid. The next accepted pixel
//   must be row 0. Any window already in flight is discarded.
// - Width rules: pass-through only, no arithmetic. Zero taps are all-zero DATA_W.
// STRUCTURE
// - Shared package dfdd_pkg holds:
//   - IMG_W/IMG_H defaults and PIX_W=18
//   - typedef logic signed [PIX_W-1:0] pix_t
//   - typedef pix_t win5_t [5][1]
//   - typedef enum {LB_RUN, LB_FLUSH} lb_state_t
// - Sub-module: sdp_ram_rf (simple dual-port, read-first, 1-cycle registered read).
//   Width DATA_W, depth IMG_W, instantiated 4x.
// - Top level holds the slot mux (rotate by row[1:0]), the FSM, the flush counters,
//   zero-pad masking and the output regs.
// TESTING (IMG_W=8, IMG_H=6, pixel = row*16+col, signed)
// - Reset mid-stream: drive rst_i=0 during row 3 -> valid_o=0, busy_o=0, overflow_o=0
//   in the same cycle (async).
// - Top border: feed rows 0..2.
//   - No valid_o for rows 0-1.
//   - First window appears 2 cycles after pixel (2,0): row_o=0, col_o=0, window={0,0,0,16,32}.
// - Steady state: pixel (4,5) -> 2 cycles later row_o=2, col_o=5, window={5,21,37,53,69}.
// - Flush: after (5,7) busy_o=1 for 16 cycles.
//   - Windows for row 4: {37,53,69,85,0} at col 5.
//   - Windows for row 5: {53,69,85,0,0} at col 5.
//   - Total valid_o count per frame = 48.
// - Overflow: assert valid_i during FLUSH -> overflow_o=1 and stays high.
//   No extra valid_o. The flush window sequence is unchanged.
// - Back-to-back frames with negative data (pixel = -(row*16+col)):
//   - The 2nd frame's row-0 window has [0]=[1]=0, independent of stale RAM.
//   - The sign of negative pixels is preserved.

Source files
------------

// File: rtl/dfdd_pkg.sv
// Shared types for the DFDD Burt pyramid: pixel type, window type, line-buffer FSM states
// and the stage-1 bookkeeping struct carried alongside the line RAM read.
package dfdd_pkg;
  localparam int DFDD_IMG_W = 640;
  localparam int DFDD_IMG_H = 480;
  localparam int PIX_W      = 18;

  typedef logic signed [PIX_W-1:0] pix_t;
  typedef pix_t win5_t [5][1];

  typedef enum logic {LB_RUN, LB_FLUSH} lb_state_t;

  // Rows are carried as a "virtual" row: during flush it runs past the frame (H, H+1)
  // so the same tap/slot arithmetic serves both phases.
  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic        flush;
    logic        pass;
  } lb_s1_t;

  // Slot holding row (row - 4 + k); -4 vanishes modulo the 4 slots.
  function automatic logic [1:0] slot_of(input logic [15:0] row, input int k);
    return row[1:0] + 2'(k);
  endfunction
endpackage

// File: rtl/sdp_ram_rf.sv
// Simple dual-port line RAM: one write port, one read port, registered read.
// A same-address read and write in one cycle returns the old contents.
module sdp_ram_rf #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/custom_line_buffer_v5_sint18.sv
// 5x1 vertical window generator feeding the Burt filter: 4 line RAMs rotated by row[1:0],
// a flush phase that emits the last two centre rows, zero-padding by row index.
module custom_line_buffer_v5_sint18
  import dfdd_pkg::*;
#(
  parameter int IMG_W  = DFDD_IMG_W,
  parameter int IMG_H  = DFDD_IMG_H,
  parameter int DATA_W = PIX_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic [15:0]              col_i,
  input  logic [15:0]              row_i,
  input  logic                     valid_i,
  output logic signed [DATA_W-1:0] window_o [5][1],
  output logic [15:0]              col_o,
  output logic [15:0]              row_o,
  output logic                     valid_o,
  output logic                     busy_o,
  output logic                     overflow_o
);
  localparam int            AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0]   LAST_ROW = 16'(IMG_H - 1);
  localparam logic [15:0]   LAST_COL = 16'(IMG_W - 1);
  localparam logic [AW-1:0] FC_LAST  = AW'(IMG_W - 1);

  lb_state_t state_q, state_d;
  logic      busy_q, busy_d, ovf_q, ovf_d, pass_q, pass_d;
  logic [AW-1:0] fc_q, fc_d;
  logic [2:1]    vld_pipe_q;
  logic          issue;

  lb_s1_t                   s1_q, s1_d;
  logic signed [DATA_W-1:0] s1_data_q, s1_data_d;

  logic          ram_we;
  logic [AW-1:0] raddr;
  logic [DATA_W-1:0] rd_data [4];

  logic signed [DATA_W-1:0] win_q [5];
  logic signed [DATA_W-1:0] win_d [5];
  logic [15:0] col_q, col_d, row_q, row_d;

  for (genvar s = 0; s < 4; s++) begin : g_slot
    sdp_ram_rf #(.WIDTH(DATA_W), .DEPTH(IMG_W), .AW(AW)) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we && (row_i[1:0] == 2'(s))),
      .waddr_i (col_i[AW-1:0]),
      .wdata_i (data_i),
      .raddr_i (raddr),
      .rdata_o (rd_data[s])
    );
  end

  // Stage 0: accept/flush sequencing, RAM read issue.
  always_comb begin : ctrl
    state_d   = state_q;
    busy_d    = busy_q;
    pass_d    = pass_q;
    fc_d      = fc_q;
    ovf_d     = ovf_q;
    issue     = 1'b0;
    ram_we    = 1'b0;
    raddr     = col_i[AW-1:0];
    s1_d      = s1_q;
    s1_data_d = s1_data_q;
    unique case (state_q)
      LB_RUN: if (valid_i) begin
        ram_we    = 1'b1;
        issue     = (row_i >= 16'd2);
        s1_d      = '{col: col_i, row: row_i, flush: 1'b0, pass: 1'b0};
        s1_data_d = data_i;
        if (row_i == LAST_ROW && col_i == LAST_COL) begin
          state_d = LB_FLUSH;
          busy_d  = 1'b1;
          fc_d    = '0;
          pass_d  = 1'b0;
        end
      end
      LB_FLUSH: begin
        ovf_d     = ovf_q | valid_i;
        issue     = 1'b1;
        raddr     = fc_q;
        s1_d      = '{col: 16'(fc_q), row: 16'(IMG_H) + {15'd0, pass_q},
                      flush: 1'b1, pass: pass_q};
        s1_data_d = '0;
        if (fc_q == FC_LAST) begin
          fc_d = '0;
          if (pass_q) begin
            state_d = LB_RUN;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
          end else begin
            pass_d = 1'b1;
          end
        end else begin
          fc_d = fc_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Stage 1: pick slots for each tap, zero rows above the frame and rows past its end.
  always_comb begin : taps
    for (int k = 0; k < 4; k++) begin
      win_d[k] = rd_data[slot_of(s1_q.row, k)];
      if (s1_q.row < 16'(4 - k)) win_d[k] = '0;
    end
    if (s1_q.flush && s1_q.pass) win_d[3] = '0;
    win_d[4] = s1_q.flush ? '0 : s1_data_q;
    col_d    = s1_q.col;
    row_d    = s1_q.row - 16'd2;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= LB_RUN;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      pass_q     <= 1'b0;
      fc_q       <= '0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s1_data_q  <= '0;
      for (int k = 0; k < 5; k++) win_q[k] <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      pass_q     <= pass_d;
      fc_q       <= fc_d;
      vld_pipe_q <= {vld_pipe_q[1], issue};
      s1_q       <= s1_d;
      s1_data_q  <= s1_data_d;
      if (vld_pipe_q[1]) begin
        win_q <= win_d;
        col_q <= col_d;
        row_q <= row_d;
      end
    end
  end

  for (genvar k = 0; k < 5; k++) begin : g_win
    assign window_o[k][0] = win_q[k];
  end
  assign col_o      = col_q;
  assign row_o      = row_q;
  assign valid_o    = vld_pipe_q[2];
  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;
endmodule
